// File: rtl/adc_meas_pkg.sv
// Shared types and constants for the ADC voltage measurement front-end.
package adc_meas_pkg;

  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_ZEROS = 4;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    QUIET,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/adc_serial_rx.sv
// Single AD7476-style conversion frame: drives cs_n/sclk and shifts in the
// serial result. The frame runs as 2*FRAME_BITS+1 phases of CLK_DIV cycles:
// phase 0 is the lead-in with sclk high, odd phases are sclk low, even
// phases (>0) are sclk high. Data is captured on every low->high sclk step.
module adc_serial_rx
  import adc_meas_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                adc_sdo_i,
  output logic                adc_cs_n_o,
  output logic                adc_sclk_o,
  output logic [ADC_BITS-1:0] sample_o,
  output logic                frame_done_o
);

  localparam int unsigned NPH   = 2 * FRAME_BITS + 1;
  localparam int unsigned PH_W  = $clog2(NPH);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic                active_q, active_d;
  logic                cs_n_q,   cs_n_d;
  logic                sclk_q,   sclk_d;
  logic [DIV_W-1:0]    div_q,    div_d;
  logic [PH_W-1:0]     ph_q,     ph_d;
  logic [ADC_BITS-1:0] shift_q,  shift_d;
  logic                frame_done;

  // Next-state for the divider, phase counter, serial pins and shift register.
  // The shifter is only ADC_BITS wide, so the leading zeros fall off the top.
  always_comb begin
    active_d   = active_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    div_d      = div_q;
    ph_d       = ph_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      cs_n_d   = 1'b0;
      sclk_d   = 1'b1;
      div_d    = '0;
      ph_d     = '0;
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d = '0;
        if (ph_q == PH_W'(NPH - 1)) begin
          active_d   = 1'b0;
          cs_n_d     = 1'b1;
          sclk_d     = 1'b1;
          frame_done = 1'b1;
        end else begin
          ph_d   = ph_q + PH_W'(1);
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shift_d = {shift_q[ADC_BITS-2:0], adc_sdo_i};
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Frame registers; cs_n and sclk return high asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      div_q    <= '0;
      ph_q     <= '0;
      shift_q  <= '0;
    end else begin
      active_q <= active_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      shift_q  <= shift_d;
    end
  end

  assign adc_cs_n_o   = cs_n_q;
  assign adc_sclk_o   = sclk_q;
  assign sample_o     = shift_q;
  assign frame_done_o = frame_done;

endmodule

// File: rtl/adc_voltage_meas.sv
// Measurement front-end: runs 2^AVG_LOG2 ADC frames, averages them, scales
// the mean to millivolts and flags each new result with a done pulse.
// CALC takes exactly 2 cycles: cycle 1 registers mean*VREF_MV, cycle 2
// registers the scaled voltage. done_sig is registered off DONE so it rises
// one cycle after voltage updates.
module adc_voltage_meas
  import adc_meas_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned AVG_LOG2  = 4,
  parameter int unsigned VREF_MV   = 3300,
  parameter int unsigned QUIET_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_en,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] voltage,
  output logic        done_sig,
  output logic        busy
);

  localparam int unsigned ACC_W  = ADC_BITS + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned Q_W    = $clog2(QUIET_CYC + 1);
  localparam int unsigned PROD_W = 28;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q,   acc_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [Q_W-1:0]      quiet_q, quiet_d;
  logic                calc2_q, calc2_d;
  logic [PROD_W-1:0]   prod_q,  prod_d;
  logic [15:0]         volt_q,  volt_d;
  logic                done_q,  done_d;

  logic                start;
  logic                frame_done;
  logic [ADC_BITS-1:0] sample;
  logic [ADC_BITS-1:0] mean;

  assign mean = ADC_BITS'(acc_q >> AVG_LOG2);

  adc_serial_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .adc_sdo_i    (adc_sdo),
    .adc_cs_n_o   (adc_cs_n),
    .adc_sclk_o   (adc_sclk),
    .sample_o     (sample),
    .frame_done_o (frame_done)
  );

  // Measurement sequencing, accumulation and two-step scaling.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    quiet_d = quiet_q;
    calc2_d = calc2_q;
    prod_d  = prod_q;
    volt_d  = volt_q;
    unique case (state_q)
      IDLE: begin
        if (meas_en) state_d = CONV;
      end
      CONV: begin
        if (frame_done) begin
          acc_d   = acc_q + ACC_W'(sample);
          quiet_d = '0;
          state_d = QUIET;
        end
      end
      QUIET: begin
        if (quiet_q == Q_W'(QUIET_CYC - 1)) begin
          if (cnt_q == CNT_LAST) begin
            calc2_d = 1'b0;
            state_d = CALC;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = CONV;
          end
        end else begin
          quiet_d = quiet_q + Q_W'(1);
        end
      end
      CALC: begin
        if (!calc2_q) begin
          prod_d  = PROD_W'(mean) * PROD_W'(VREF_MV);
          calc2_d = 1'b1;
        end else begin
          volt_d  = prod_q[PROD_W-1:ADC_BITS];
          calc2_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = meas_en ? CONV : IDLE;
      end
      default: state_d = IDLE;
    endcase
    start  = (state_d == CONV) && (state_q != CONV);
    done_d = (state_q == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      quiet_q <= '0;
      calc2_q <= 1'b0;
      prod_q  <= '0;
      volt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      quiet_q <= quiet_d;
      calc2_q <= calc2_d;
      prod_q  <= prod_d;
      volt_q  <= volt_d;
      done_q  <= done_d;
    end
  end

  assign voltage  = volt_q;
  assign done_sig = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_adc_voltage_meas.sv
// Bench for adc_voltage_meas: an ADC model serves per-frame sample words and
// pushes the expected averaged millivolt result per group; a monitor pops and
// compares on each done pulse and checks frame timing.
module tb_adc_voltage_meas;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned AVG_LOG2  = 2;
  localparam int unsigned VREF_MV   = 3300;
  localparam int unsigned QUIET_CYC = 4;
  localparam int unsigned NAVG      = 1 << AVG_LOG2;
  localparam int unsigned FRAME_LOW = 33 * CLK_DIV;
  // frames + quiet gaps, plus 2-cycle CALC and 1-cycle DONE
  localparam int unsigned PERIOD    = NAVG * (FRAME_LOW + QUIET_CYC) + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_en = 1'b0;
  logic        adc_sdo = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [15:0] voltage;
  logic        done_sig;
  logic        busy;

  adc_voltage_meas #(
    .CLK_DIV   (CLK_DIV),
    .AVG_LOG2  (AVG_LOG2),
    .VREF_MV   (VREF_MV),
    .QUIET_CYC (QUIET_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .meas_en  (meas_en),
    .adc_sdo  (adc_sdo),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .voltage  (voltage),
    .done_sig (done_sig),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  int unsigned dataq[$];
  int unsigned expq[$];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act < req) begin
      errors++;
      $display("FAIL %s: got %0d required >= %0d", name, act, req);
    end
  endtask

  // ADC model: new word on cs_n fall, bit k of {4'b0,data} on the k-th sclk fall
  logic [11:0] cur = '0;
  logic [15:0] word;
  int unsigned bitk = 16;
  int unsigned grp_sum = 0;
  int unsigned grp_n = 0;
  always @(negedge adc_cs_n or negedge adc_sclk or negedge rst_n) begin
    if (!rst_n) begin
      grp_sum = 0;
      grp_n   = 0;
      bitk    = 16;
      expq.delete();
    end else if (adc_sclk === 1'b1 && adc_cs_n === 1'b0) begin
      if (dataq.size() > 0) cur = 12'(dataq.pop_front());
      else                  cur = 12'($urandom_range(0, 4095));
      bitk    = 0;
      adc_sdo = 1'b0;
    end else if (adc_cs_n === 1'b0 && bitk < 16) begin
      word    = {4'b0000, cur};
      adc_sdo = word[15 - bitk];
      bitk++;
      if (bitk == 16) begin
        grp_sum += cur;
        grp_n++;
        if (grp_n == NAVG) begin
          expq.push_back(((grp_sum / NAVG) * VREF_MV) / 4096);
          grp_sum = 0;
          grp_n   = 0;
        end
      end
    end
  end

  // Monitor: scoreboard compare on done, pulse width, frame and gap timing
  logic        prev_cs = 1'b1;
  logic        prev_done = 1'b0;
  logic [15:0] prev_v = '0;
  bit          have_frame = 0;
  int unsigned low_cnt = 0;
  int unsigned high_cnt = 0;
  int unsigned frames = 0;
  int unsigned done_cnt = 0;
  int unsigned cs_falls = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs    = 1'b1;
      prev_done  = 1'b0;
      prev_v     = voltage;
      have_frame = 0;
      frames     = 0;
      low_cnt    = 0;
      high_cnt   = 0;
    end else begin
      if (prev_done) check("done_width", done_sig, 0);
      if (done_sig && !prev_done) begin
        done_cnt++;
        check("frames_per_result", frames, NAVG);
        frames = 0;
        check("voltage_settled_before_done", voltage, prev_v);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got voltage %0d, required no done pulse", voltage);
        end else begin
          check("voltage", voltage, expq.pop_front());
        end
      end
      if (!adc_cs_n) begin
        if (prev_cs) begin
          cs_falls++;
          frames++;
          if (have_frame) check_ge("quiet_gap", high_cnt, QUIET_CYC);
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
      end else begin
        if (!prev_cs) begin
          check("cs_low_len", low_cnt, FRAME_LOW);
          have_frame = 1;
          high_cnt   = 1;
        end else begin
          high_cnt++;
        end
      end
      prev_cs   = adc_cs_n;
      prev_done = done_sig;
      prev_v    = voltage;
    end
  end

  task automatic wait_dones(input int unsigned n, input string name);
    int unsigned target;
    int unsigned budget;
    int unsigned k;
    target = done_cnt + n;
    budget = n * (PERIOD + 100) + 200;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d done pulses required %0d", name, n - (target - done_cnt), n);
    end
  endtask

  task automatic wait_frame2(input bit need_low, input string name);
    int unsigned k;
    k = 0;
    while (!(frames == 2 && (!need_low || adc_sclk == 1'b0)) && k < 2 * PERIOD) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!(frames == 2 && (!need_low || adc_sclk == 1'b0))) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got frame %0d required frame 2", name, frames);
    end
  endtask

  int unsigned t0, t1, t2, t3, falls0, dc0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_voltage", voltage, 0);
    check("rst_done", done_sig, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_cs_n", adc_cs_n, 1);

    // Full scale, mid scale, alternating extremes, then two random groups
    repeat (4) dataq.push_back(4095);
    repeat (4) dataq.push_back(2048);
    dataq.push_back(0); dataq.push_back(4095); dataq.push_back(0); dataq.push_back(4095);
    meas_en = 1'b1;
    wait_dones(5, "first_results");

    // meas_en drop during frame 2: group still completes, then idle
    wait_frame2(1'b0, "drop_frame");
    meas_en = 1'b0;
    wait_dones(1, "drop_result");
    repeat (2) @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_cs_n", adc_cs_n, 1);
    falls0 = cs_falls;
    dc0    = done_cnt;
    repeat (300) @(negedge clk);
    check("idle_no_frames", cs_falls, falls0);
    check("idle_no_done", done_cnt, dc0);

    // Async reset mid-frame while sclk is low
    meas_en = 1'b1;
    wait_frame2(1'b1, "reset_point");
    #1 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_sclk", adc_sclk, 1);
    check("midrst_voltage", voltage, 0);
    check("midrst_done", done_sig, 0);
    check("midrst_busy", busy, 0);
    dataq.delete();
    repeat (4) dataq.push_back(3000);
    repeat (12) dataq.push_back(1000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fresh result after reset, then three back-to-back results
    wait_dones(1, "post_reset");
    t0 = cyc;
    wait_dones(1, "cont1");
    t1 = cyc;
    wait_dones(1, "cont2");
    t2 = cyc;
    wait_dones(1, "cont3");
    t3 = cyc;
    check("period1", t1 - t0, PERIOD);
    check("period2", t2 - t1, PERIOD);
    check("period3", t3 - t2, PERIOD);

    meas_en = 1'b0;
    wait_dones(1, "final");
    repeat (10) @(negedge clk);
    check("final_busy", busy, 0);
    check("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
